pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flow controller: load-use stalls, taken-branch flushes,
// instruction-memory wait handling, halt, and stall/timeout bookkeeping.
module pipe_ctrl #(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned WAIT_LIMIT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  in_id_rs,
  input  logic [5:0]  in_id_rt,
  input  logic        in_id_uses_rs,
  input  logic        in_id_uses_rt,
  input  logic        in_ex_memread,
  input  logic [5:0]  in_ex_rd,
  input  logic        in_branch_taken,
  input  logic        in_imem_ready,
  input  logic        in_halt,
  output logic        out_pc_we,
  output logic        out_ifid_we,
  output logic        out_ifid_flush,
  output logic        out_idex_flush,
  output logic [1:0]  out_state,
  output logic [15:0] out_stall_count,
  output logic        out_timeout
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_DEPTH - 1);
  localparam logic [7:0] WAIT_MAX     = 8'(WAIT_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_q, timeout_d;

  logic pc_we, ifid_we, ifid_flush, idex_flush;
  logic load_use;

  assign load_use = in_ex_memread && (in_ex_rd != 6'd0) &&
                    ((in_id_uses_rs && (in_id_rs == in_ex_rd)) ||
                     (in_id_uses_rt && (in_id_rt == in_ex_rd)));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;

    if (state_q == ST_HALT) begin
      idex_flush = 1'b1;
    end else if (in_halt) begin
      idex_flush = 1'b1;
      state_d    = ST_HALT;
    end else if (in_branch_taken) begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (FLUSH_DEPTH == 1) begin
        state_d = ST_RUN;
      end else begin
        flush_cnt_d = FLUSH_RELOAD;
        state_d     = ST_FLUSH;
      end
    end else if (load_use) begin
      // Bubble into EX while PC and IF/ID hold; state and counters freeze.
      idex_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          ifid_we = 1'b1;
          if (!in_imem_ready) begin
            ifid_flush = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = ST_WAIT;
          end else begin
            pc_we = 1'b1;
          end
        end
        ST_WAIT: begin
          ifid_we = 1'b1;
          if (!in_imem_ready) begin
            ifid_flush = 1'b1;
            if (wait_cnt_q < WAIT_MAX) wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            pc_we   = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // Fetched data is discarded here anyway, so imem readiness is not consulted.
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_d = 4'd0;
            state_d     = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    timeout_d = timeout_q || (wait_cnt_d == WAIT_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 4'd0;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Enables are gated by rst_n so they drop to 0 immediately while reset is held.
  assign out_pc_we       = rst_n && pc_we;
  assign out_ifid_we     = rst_n && ifid_we;
  assign out_ifid_flush  = rst_n && ifid_flush;
  assign out_idex_flush  = rst_n && idex_flush;
  assign out_state       = state_q;
  assign out_stall_count = stall_cnt_q;
  assign out_timeout     = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (FLUSH_DEPTH=2, WAIT_LIMIT=4): directed
// stimulus with per-cycle expectations queued and compared at the falling edge.
module tb_pipe_ctrl;

  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_FLUSH = 2'd2, S_HALT = 2'd3;

  typedef struct packed {
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic [1:0]  state;
    logic [15:0] stall;
    logic        timeout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  id_rs, id_rt, ex_rd;
  logic        uses_rs, uses_rt, ex_memread, branch, imem_ready, halt;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, timeout;
  logic [1:0]  state;
  logic [15:0] stall_count;

  exp_t        sb_q[$];
  logic [15:0] exp_stall;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_DEPTH(2), .WAIT_LIMIT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_id_rs        (id_rs),
    .in_id_rt        (id_rt),
    .in_id_uses_rs   (uses_rs),
    .in_id_uses_rt   (uses_rt),
    .in_ex_memread   (ex_memread),
    .in_ex_rd        (ex_rd),
    .in_branch_taken (branch),
    .in_imem_ready   (imem_ready),
    .in_halt         (halt),
    .out_pc_we       (pc_we),
    .out_ifid_we     (ifid_we),
    .out_ifid_flush  (ifid_flush),
    .out_idex_flush  (idex_flush),
    .out_state       (state),
    .out_stall_count (stall_count),
    .out_timeout     (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs = 6'd0; id_rt = 6'd0; ex_rd = 6'd0;
    uses_rs = 1'b0; uses_rt = 1'b0; ex_memread = 1'b0;
    branch = 1'b0; imem_ready = 1'b1; halt = 1'b0;
  endtask

  task automatic hazard_rs(input logic [5:0] r);
    ex_memread = 1'b1; ex_rd = r; id_rs = r; uses_rs = 1'b1;
  endtask

  // Called just after a rising edge with inputs already driven for this cycle.
  task automatic cyc(input string tag, input logic p, input logic iw, input logic ifl,
                     input logic idf, input logic [1:0] st, input logic to);
    exp_t e, got_e;
    e = '{pc_we: p, ifid_we: iw, ifid_flush: ifl, idex_flush: idf,
          state: st, stall: exp_stall, timeout: to};
    sb_q.push_back(e);
    if (!p && st != S_HALT && exp_stall != 16'hFFFF) exp_stall++;
    @(negedge clk);
    got_e = sb_q.pop_front();
    check({tag, ".pc_we"},      32'(pc_we),       32'(got_e.pc_we));
    check({tag, ".ifid_we"},    32'(ifid_we),     32'(got_e.ifid_we));
    check({tag, ".ifid_flush"}, 32'(ifid_flush),  32'(got_e.ifid_flush));
    check({tag, ".idex_flush"}, 32'(idex_flush),  32'(got_e.idex_flush));
    check({tag, ".state"},      32'(state),       32'(got_e.state));
    check({tag, ".stall"},      32'(stall_count), 32'(got_e.stall));
    check({tag, ".timeout"},    32'(timeout),     32'(got_e.timeout));
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc_we"},      32'(pc_we),       32'd0);
    check({tag, ".ifid_we"},    32'(ifid_we),     32'd0);
    check({tag, ".ifid_flush"}, 32'(ifid_flush),  32'd0);
    check({tag, ".idex_flush"}, 32'(idex_flush),  32'd0);
    check({tag, ".state"},      32'(state),       32'(S_RUN));
    check({tag, ".stall"},      32'(stall_count), 32'd0);
    check({tag, ".timeout"},    32'(timeout),     32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall = 16'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    exp_stall = 16'd0;
    #1;
    check_reset("rst_init");
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_held");
    release_reset();

    // Load-use hazard on rs, then the ex_rd=0 and non-used-operand cases.
    idle(); cyc("run_idle", 1, 1, 0, 0, S_RUN, 0);
    hazard_rs(6'd5); cyc("lu_rs", 0, 0, 0, 1, S_RUN, 0);
    idle(); cyc("lu_after", 1, 1, 0, 0, S_RUN, 0);
    hazard_rs(6'd0); cyc("lu_rd0", 1, 1, 0, 0, S_RUN, 0);
    idle(); ex_memread = 1; ex_rd = 6'd7; id_rt = 6'd7; uses_rt = 1;
    cyc("lu_rt", 0, 0, 0, 1, S_RUN, 0);
    uses_rt = 0; cyc("lu_rt_unused", 1, 1, 0, 0, S_RUN, 0);
    idle(); ex_memread = 1; ex_rd = 6'd9; id_rs = 6'd8; uses_rs = 1;
    cyc("lu_mismatch", 1, 1, 0, 0, S_RUN, 0);

    // Taken branch: two bubble cycles, RUN -> FLUSH -> RUN.
    idle(); branch = 1; cyc("br", 1, 1, 1, 1, S_RUN, 0);
    idle(); cyc("br_flush", 1, 1, 1, 0, S_FLUSH, 0);
    cyc("br_done", 1, 1, 0, 0, S_RUN, 0);

    // Branch beats a simultaneous load-use hazard.
    hazard_rs(6'd3); branch = 1; cyc("br_lu", 1, 1, 1, 1, S_RUN, 0);
    idle(); cyc("br_lu_flush", 1, 1, 1, 0, S_FLUSH, 0);
    cyc("br_lu_done", 1, 1, 0, 0, S_RUN, 0);

    // Hazard inside FLUSH holds the flush counter.
    branch = 1; cyc("brh", 1, 1, 1, 1, S_RUN, 0);
    idle(); hazard_rs(6'd4); cyc("brh_lu", 0, 0, 0, 1, S_FLUSH, 0);
    idle(); cyc("brh_flush", 1, 1, 1, 0, S_FLUSH, 0);
    cyc("brh_done", 1, 1, 0, 0, S_RUN, 0);

    // Branch inside FLUSH reloads the counter.
    branch = 1; cyc("brr", 1, 1, 1, 1, S_RUN, 0);
    cyc("brr_again", 1, 1, 1, 1, S_FLUSH, 0);
    idle(); cyc("brr_flush", 1, 1, 1, 0, S_FLUSH, 0);
    cyc("brr_done", 1, 1, 0, 0, S_RUN, 0);

    // Three imem-wait cycles: no timeout with WAIT_LIMIT=4.
    imem_ready = 0; cyc("w3_0", 0, 1, 1, 0, S_RUN, 0);
    cyc("w3_1", 0, 1, 1, 0, S_WAIT, 0);
    cyc("w3_2", 0, 1, 1, 0, S_WAIT, 0);
    imem_ready = 1; cyc("w3_rdy", 1, 1, 0, 0, S_WAIT, 0);
    cyc("w3_run", 1, 1, 0, 0, S_RUN, 0);

    // Six imem-wait cycles: wait counter reaches 4, timeout sets and sticks.
    imem_ready = 0; cyc("w6_0", 0, 1, 1, 0, S_RUN, 0);
    cyc("w6_1", 0, 1, 1, 0, S_WAIT, 0);
    cyc("w6_2", 0, 1, 1, 0, S_WAIT, 0);
    cyc("w6_3", 0, 1, 1, 0, S_WAIT, 0);
    cyc("w6_4", 0, 1, 1, 0, S_WAIT, 0);
    cyc("w6_5", 0, 1, 1, 0, S_WAIT, 1);
    imem_ready = 1; cyc("w6_rdy", 1, 1, 0, 0, S_WAIT, 1);
    cyc("w6_sticky", 1, 1, 0, 0, S_RUN, 1);

    // Halt arriving during FLUSH; HALT then ignores every input.
    branch = 1; cyc("h_br", 1, 1, 1, 1, S_RUN, 1);
    idle(); halt = 1; cyc("h_enter", 0, 0, 0, 1, S_FLUSH, 1);
    idle(); branch = 1; cyc("h_br_ign", 0, 0, 0, 1, S_HALT, 1);
    idle(); hazard_rs(6'd2); imem_ready = 0; cyc("h_all_ign", 0, 0, 0, 1, S_HALT, 1);
    idle(); cyc("h_idle", 0, 0, 0, 1, S_HALT, 1);

    // Reset pulse clears everything and exits HALT.
    rst_n = 1'b0; #1;
    check_reset("rst_halt");
    release_reset();
    cyc("post_rst", 1, 1, 0, 0, S_RUN, 0);

    // Saturation: more than 65535 consecutive load-use stall cycles.
    hazard_rs(6'd6);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      if (exp_stall != 16'hFFFF) exp_stall++;
    end
    #1;
    cyc("sat", 0, 0, 0, 1, S_RUN, 0);
    cyc("sat_hold", 0, 0, 0, 1, S_RUN, 0);
    check("sat_value", 32'(stall_count), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
